// File: rtl/uart_tx_if.sv
// TX FIFO read port seen from the transmitter: pop request out, word and empty flag in.
// The word is valid on the cycle after the pop request.
interface uart_tx_if #(
  parameter int DataLength = 8
);
  logic [DataLength-1:0] tx_data;
  logic                  tx_fifo_empty;
  logic                  tx_fifo_read_en;

  modport master (
    input  tx_data,
    input  tx_fifo_empty,
    output tx_fifo_read_en
  );

  modport slave (
    output tx_data,
    output tx_fifo_empty,
    input  tx_fifo_read_en
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops a word from the TX FIFO and serialises start, data (LSB first),
// optional parity and stop bits onto o_tx, one bit per prescaler strobe.
module uart_tx #(
  parameter bit ErrorChecking = 1'b0,
  parameter bit ParityEven    = 1'b0,
  parameter int StopBits      = 1,
  parameter int DataLength    = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  output logic      o_tx,
  uart_tx_if.master fifo,
  input  logic      i_strobe,
  output logic      o_prescaler_en,
  output logic      o_busy
);

  localparam int CntW = $clog2(DataLength);
  localparam logic [CntW-1:0] BitCntInit = CntW'(DataLength - 1);
  localparam logic StopCntInit = 1'(StopBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DataLength-1:0] shift_q;
  logic [CntW-1:0]       bit_cnt;
  logic                  stop_cnt;
  logic                  parity_q;
  logic                  pop;

  function automatic logic parity_bit(input logic [DataLength-1:0] word);
    return ParityEven ? (^word) : (~^word);
  endfunction

  // The pop is combinational so the FIFO word arrives while the FSM sits in FETCH.
  assign pop                  = (state == IDLE) && !fifo.tx_fifo_empty && !i_rst;
  assign fifo.tx_fifo_read_en = pop;
  assign o_busy               = (state != IDLE) || pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      o_tx           <= 1'b1;
      o_prescaler_en <= 1'b0;
      shift_q        <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= 1'b0;
      parity_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (pop) state <= FETCH;
        end

        FETCH: begin
          shift_q        <= fifo.tx_data;
          parity_q       <= parity_bit(fifo.tx_data);
          bit_cnt        <= BitCntInit;
          o_tx           <= 1'b0;
          o_prescaler_en <= 1'b1;
          state          <= START;
        end

        START: begin
          if (i_strobe) begin
            o_tx  <= shift_q[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (i_strobe) begin
            if (bit_cnt == '0) begin
              if (ErrorChecking) begin
                o_tx  <= parity_q;
                state <= PARITY;
              end else begin
                o_tx     <= 1'b1;
                stop_cnt <= StopCntInit;
                state    <= STOP;
              end
            end else begin
              // shift_q[0] is on the line now; shift_q[1] becomes the next bit
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt - 1'b1;
              o_tx    <= shift_q[1];
            end
          end
        end

        PARITY: begin
          if (i_strobe) begin
            o_tx     <= 1'b1;
            stop_cnt <= StopCntInit;
            state    <= STOP;
          end
        end

        STOP: begin
          if (i_strobe) begin
            if (stop_cnt == 1'b0) begin
              o_prescaler_en <= 1'b0;
              state          <= IDLE;
            end else begin
              stop_cnt <= stop_cnt - 1'b1;
            end
          end
        end

        default: begin
          o_tx           <= 1'b1;
          o_prescaler_en <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parameterisations fed by FIFO models, frames decoded from the
// serial line by per-instance monitors and checked against queued expected words.
module tb_uart_tx;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  localparam int EC[3] = '{0, 1, 1};
  localparam int SB[3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] strobe;
  logic [2:0] tx_w, rd_w, pen_w, busy_w;
  logic [2:0] empty;
  logic [7:0] txd[3];
  logic       rand_mode;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         pops[3] = '{0, 0, 0};
  int         busy_cyc[3] = '{0, 0, 0};
  int         pcnt[3] = '{0, 0, 0};
  logic [11:0] last_bits[3];

  logic [7:0] wq[3][$];
  exp_t       exp_q[3][$];
  int         start_t[3][$];

  always #5 clk = ~clk;

  uart_tx_if #(.DataLength(8)) f0 ();
  uart_tx_if #(.DataLength(8)) f1 ();
  uart_tx_if #(.DataLength(8)) f2 ();

  assign f0.tx_data = txd[0];
  assign f1.tx_data = txd[1];
  assign f2.tx_data = txd[2];
  assign f0.tx_fifo_empty = empty[0];
  assign f1.tx_fifo_empty = empty[1];
  assign f2.tx_fifo_empty = empty[2];
  assign rd_w = {f2.tx_fifo_read_en, f1.tx_fifo_read_en, f0.tx_fifo_read_en};

  uart_tx #(.ErrorChecking(1'b0), .ParityEven(1'b0), .StopBits(1), .DataLength(8)) u0 (
    .i_clk(clk), .i_rst(rst), .o_tx(tx_w[0]), .fifo(f0),
    .i_strobe(strobe[0]), .o_prescaler_en(pen_w[0]), .o_busy(busy_w[0]));

  uart_tx #(.ErrorChecking(1'b1), .ParityEven(1'b1), .StopBits(2), .DataLength(8)) u1 (
    .i_clk(clk), .i_rst(rst), .o_tx(tx_w[1]), .fifo(f1),
    .i_strobe(strobe[1]), .o_prescaler_en(pen_w[1]), .o_busy(busy_w[1]));

  uart_tx #(.ErrorChecking(1'b1), .ParityEven(1'b0), .StopBits(1), .DataLength(8)) u2 (
    .i_clk(clk), .i_rst(rst), .o_tx(tx_w[2]), .fifo(f2),
    .i_strobe(strobe[2]), .o_prescaler_en(pen_w[2]), .o_busy(busy_w[2]));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) busy_cyc[d] <= busy_cyc[d] + int'(busy_w[d]);
  end

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, got, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] data, input logic par);
    wq[d].push_back(data);
    exp_q[d].push_back('{data: data, par: par});
  endtask

  // Prescaler model: first strobe one full 16-clock period after the enable rises.
  initial begin
    strobe = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (rand_mode) begin
          strobe[d] = 1'($urandom_range(0, 1));
        end else if (!pen_w[d]) begin
          pcnt[d]   = 0;
          strobe[d] = 1'b0;
        end else begin
          pcnt[d]++;
          strobe[d] = (pcnt[d] == 16);
          if (pcnt[d] == 16) pcnt[d] = 0;
        end
      end
    end
  end

  task automatic fifo_model(input int d);
    logic [7:0] w;
    txd[d]   = 8'($urandom);
    empty[d] = 1'b1;
    forever begin
      @(negedge clk);
      empty[d] = (wq[d].size() == 0);
      #1;
      if (rd_w[d]) begin
        pops[d]++;
        check("pop_nonempty", d, 32'(wq[d].size() != 0), 1);
        if (wq[d].size() != 0) begin
          w = wq[d].pop_front();
          @(posedge clk);
          #1 txd[d] = w;
          @(posedge clk);
          #1 txd[d] = ~w;
        end
      end
    end
  endtask

  task automatic mon(input int d);
    logic [11:0] bits;
    logic        bitv;
    logic [1:0]  stopv;
    bit          ok, aborted;
    int          nb;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst && tx_w[d] == 1'b0) begin
        nb = 9 + EC[d] + SB[d];
        bits = '0; ok = 1'b1; aborted = 1'b0; bitv = 1'b0;
        start_t[d].push_back(cyc);
        for (int b = 0; b < nb && !aborted; b++) begin
          for (int s = 0; s < 16; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (s == 0) bitv = tx_w[d];
            else if (tx_w[d] !== bitv) ok = 1'b0;
          end
          bits[b] = bitv;
        end
        if (aborted) begin
          if (exp_q[d].size() != 0) e = exp_q[d].pop_front();
        end else if (exp_q[d].size() == 0) begin
          check("spurious_frame", d, 1, 0);
        end else begin
          e = exp_q[d].pop_front();
          stopv = (SB[d] == 2) ? {bits[nb-1], bits[nb-2]} : {1'b1, bits[nb-1]};
          check("data", d, 32'(bits[8:1]), 32'(e.data));
          if (EC[d] != 0) check("parity", d, 32'(bits[9]), 32'(e.par));
          check("stop_bits", d, 32'(stopv), 32'b11);
          check("bit_timing", d, 32'(ok), 1);
          last_bits[d] = bits;
        end
      end
    end
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    int pend;
    do begin
      @(negedge clk);
      n++;
      pend = 0;
      for (int d = 0; d < 3; d++) pend += exp_q[d].size() + wq[d].size();
    end while ((pend != 0 || busy_w != 3'b000) && n < maxc);
    check({"timeout_", tag}, 0, 32'(n >= maxc), 0);
  endtask

  task automatic check_gap(input int d, input int idx, input int exp_gap, input string tag);
    check({"frame_count_", tag}, d, 32'(start_t[d].size() >= idx + 2), 1);
    if (start_t[d].size() >= idx + 2)
      check({"frame_gap_", tag}, d, 32'(start_t[d][idx+1] - start_t[d][idx]), 32'(exp_gap));
  endtask

  initial begin
    int p[3], b[3], s[3];
    int n;
    bit bad_tx[3], bad_ctl[3];
    rst = 1'b1;
    rand_mode = 1'b0;
    fork
      fifo_model(0); fifo_model(1); fifo_model(2);
      mon(0); mon(1); mon(2);
    join_none

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check("reset_outputs", d, 32'({tx_w[d], rd_w[d], pen_w[d], busy_w[d]}), 32'b1000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single A5 frame on every instance; parity even=0, odd=1.
    for (int d = 0; d < 3; d++) begin p[d] = pops[d]; b[d] = busy_cyc[d]; end
    push(0, 8'hA5, 1'b0);
    push(1, 8'hA5, 1'b0);
    push(2, 8'hA5, 1'b1);
    wait_idle(800, "single");
    check("raw_frame_A5", 0, 32'(last_bits[0]), 32'h34A);
    check("raw_frame_A5", 1, 32'(last_bits[1]), 32'hD4A);
    check("raw_frame_A5", 2, 32'(last_bits[2]), 32'h74A);
    check("busy_clocks", 0, 32'(busy_cyc[0] - b[0]), 162);
    check("busy_clocks", 1, 32'(busy_cyc[1] - b[1]), 194);
    check("busy_clocks", 2, 32'(busy_cyc[2] - b[2]), 178);
    for (int d = 0; d < 3; d++) check("read_en_pulses_single", d, 32'(pops[d] - p[d]), 1);

    // Back-to-back pairs: 2 idle-high clocks between frames.
    for (int d = 0; d < 3; d++) begin p[d] = pops[d]; s[d] = start_t[d].size(); end
    push(0, 8'h00, 1'b0); push(0, 8'hFF, 1'b0);
    push(1, 8'h07, 1'b1); push(1, 8'hFF, 1'b0);
    push(2, 8'h07, 1'b0); push(2, 8'h00, 1'b1);
    wait_idle(1500, "pair");
    check_gap(0, s[0], 162, "pair");
    check_gap(1, s[1], 194, "pair");
    check_gap(2, s[2], 178, "pair");
    for (int d = 0; d < 3; d++) check("read_en_pulses_pair", d, 32'(pops[d] - p[d]), 2);

    // Two stop bits hold the line high for two periods before the next start.
    s[1] = start_t[1].size();
    push(1, 8'h3C, 1'b0); push(1, 8'h3C, 1'b0);
    wait_idle(1000, "stop2");
    check_gap(1, s[1], 194, "stop2");

    // Reset in data bit 3 of 5A aborts the frame without a re-pop.
    push(0, 8'h5A, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (tx_w[0] !== 1'b0 && n < 50);
    check("timeout_start_5A", 0, 32'(n >= 50), 0);
    p[0] = pops[0];
    repeat (69) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_tx_high", 0, 32'(tx_w[0]), 1);
    check("abort_ctl", 0, 32'({busy_w[0], pen_w[0], rd_w[0]}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_repop", 0, 32'(pops[0] - p[0]), 0);
    check("idle_after_abort", 0, 32'({tx_w[0], busy_w[0]}), 32'b10);
    push(0, 8'hC3, 1'b0);
    wait_idle(600, "after_abort");
    check("read_en_after_abort", 0, 32'(pops[0] - p[0]), 1);

    // Empty FIFO with random strobes: line and controls stay quiet.
    for (int d = 0; d < 3; d++) begin p[d] = pops[d]; bad_tx[d] = 0; bad_ctl[d] = 0; end
    rand_mode = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (tx_w[d] !== 1'b1) bad_tx[d] = 1'b1;
        if (rd_w[d] !== 1'b0 || pen_w[d] !== 1'b0) bad_ctl[d] = 1'b1;
      end
    end
    rand_mode = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("idle_tx_high", d, 32'(bad_tx[d]), 0);
      check("idle_ctl_low", d, 32'(bad_ctl[d]), 0);
      check("idle_no_pop", d, 32'(pops[d] - p[d]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
